// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL / CPU reset sequencer:
//   - state_e  : FSM state encodings (also exported on state_o for debug)
//   - DEF_*    : default timing constants used as parameter defaults
// -----------------------------------------------------------------------------
package pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_SW_RST    = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYC = 16;
  localparam int DEF_LOCK_TMO    = 4096;
  localparam int DEF_STABLE_CYC  = 1024;
  localparam int DEF_SW_RST_CYC  = 8;
  localparam int DEF_MAX_RETRY   = 3;
  localparam int DEF_CNT_W       = 16;

endpackage : pll_rst_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (both flops clear to 0)
//   d_i   - asynchronous input
//   q_o   - synchronised output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
// Sequences the board PLL and generates the CPU reset. The PLL reset is
// pulsed, lock is awaited with a timeout/retry, lock must then remain stable
// for STABLE_CYC cycles before the CPU reset is released. Lock loss while
// running re-sequences the PLL; a software request gives a CPU-only reset.
// Runs on the PLL input clock, which is valid before lock.
// Ports:
//   clk        - PLL input clock
//   rst_n      - asynchronous active-low reset
//   pll_locked - PLL lock (asynchronous, synchronised internally)
//   sw_rst_req - single-cycle software CPU-reset request (honoured in RUN only)
//   pll_reset  - PLL reset, active high
//   cpu_rst_n  - CPU/system reset, active low
//   sys_ready  - high only in RUN
//   lock_err   - sticky: MAX_RETRY lock timeouts occurred
//   retry_cnt  - lock timeouts since last RUN, saturating at MAX_RETRY
//   state_o    - current state encoding (debug)
// All outputs are registered and decoded from the next state, so they move
// on the same edge as the state register.
// -----------------------------------------------------------------------------
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYC = DEF_PLL_RST_CYC,
  parameter int LOCK_TMO    = DEF_LOCK_TMO,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int SW_RST_CYC  = DEF_SW_RST_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,   // must fit the 2-bit retry_cnt
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       pll_reset,
  output logic       cpu_rst_n,
  output logic       sys_ready,
  output logic       lock_err,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_TMO_LAST = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] SW_RST_LAST  = CNT_W'(SW_RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       retry_inc;
  logic             err_q, err_d;
  logic             pll_reset_q, cpu_rst_n_q, sys_ready_q;
  logic             locked_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  assign retry_inc = retry_q + 2'd1;

  // Next-state, counter, retry and error-flag logic.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    err_d   = err_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock seen in the timeout cycle still counts as a success.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_TMO_LAST) begin
          state_d = ST_PLL_RST;
          if (retry_q != RETRY_MAX) begin
            retry_d = retry_inc;
            if (retry_inc == RETRY_MAX) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            retry_d = retry_q;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        // A glitch here just restarts the lock wait; it is not a timeout.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (sw_rst_req) begin
          state_d = ST_SW_RST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SW_RST: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (cnt_q == SW_RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SW_RST;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    // Entering (or staying in) RUN means lock was achieved: forget timeouts.
    if (state_d == ST_RUN) begin
      retry_d = 2'd0;
    end else begin
      retry_d = retry_d;
    end

    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State, counter, status and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= {CNT_W{1'b0}};
      retry_q     <= 2'd0;
      err_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      cpu_rst_n_q <= 1'b0;
      sys_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      pll_reset_q <= (state_d == ST_PLL_RST);
      cpu_rst_n_q <= (state_d == ST_RUN);
      sys_ready_q <= (state_d == ST_RUN);
    end
  end

  assign pll_reset = pll_reset_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign sys_ready = sys_ready_q;
  assign lock_err  = err_q;
  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule : pll_rst_seq

// File: tb/tb_pll_rst_seq.sv
`timescale 1ns/1ps
module tb_pll_rst_seq;

  localparam int PR  = 4;
  localparam int TMO = 20;
  localparam int ST  = 8;
  localparam int SW  = 3;
  localparam int MR  = 3;

  // Phase numbers are the externally visible state codes.
  localparam int P_PLLRST = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_SWRST  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       pll_reset;
  logic       cpu_rst_n;
  logic       sys_ready;
  logic       lock_err;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: phase, edge of entry into phase, timeouts since RUN.
  int m_ph;
  int m_entry;
  int m_edge;
  int m_tmo;
  bit m_err;
  bit lh0, lh1;       // pll_locked sampled 1 and 2 edges ago
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .PLL_RST_CYC (PR),
    .LOCK_TMO    (TMO),
    .STABLE_CYC  (ST),
    .SW_RST_CYC  (SW),
    .MAX_RETRY   (MR),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .pll_reset  (pll_reset),
    .cpu_rst_n  (cpu_rst_n),
    .sys_ready  (sys_ready),
    .lock_err   (lock_err),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_ph    = P_PLLRST;
    m_entry = 0;
    m_edge  = 0;
    m_tmo   = 0;
    m_err   = 1'b0;
    lh0     = 1'b0;
    lh1     = 1'b0;
  endtask

  // One rising edge of the model: phase durations measured in edges since entry.
  task automatic model_step();
    bit ls;
    int dur;
    int nxt;
    ls  = lh1;
    lh1 = lh0;
    lh0 = pll_locked;
    m_edge++;
    dur = m_edge - m_entry;
    nxt = m_ph;
    case (m_ph)
      P_PLLRST: if (dur == PR) nxt = P_WAIT;
      P_WAIT: begin
        if (ls) nxt = P_STABLE;
        else if (dur == TMO) begin
          nxt = P_PLLRST;
          m_tmo++;
          if (m_tmo >= MR) m_err = 1'b1;
        end
      end
      P_STABLE: begin
        if (!ls) nxt = P_WAIT;
        else if (dur == ST) nxt = P_RUN;
      end
      P_RUN: begin
        if (!ls) nxt = P_PLLRST;
        else if (sw_rst_req) nxt = P_SWRST;
      end
      P_SWRST: begin
        if (!ls) nxt = P_PLLRST;
        else if (dur == SW) nxt = P_RUN;
      end
      default: nxt = P_PLLRST;
    endcase
    if (nxt == P_RUN) m_tmo = 0;
    if (nxt != m_ph) m_entry = m_edge;
    m_ph = nxt;
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state_o",   32'(state_o),   32'(m_ph));
      chk("pll_reset", 32'(pll_reset), 32'(m_ph == P_PLLRST));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_ph == P_RUN));
      chk("sys_ready", 32'(sys_ready), 32'(m_ph == P_RUN));
      chk("lock_err",  32'(lock_err),  32'(m_err));
      chk("retry_cnt", 32'(retry_cnt), 32'((m_tmo > MR) ? MR : m_tmo));
    end
  end

  task automatic edge_step();
    @(posedge clk);
    if (rst_n) model_step();
  endtask

  task automatic tick();
    edge_step();
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  // Assert rst_n between edges, check outputs react with no clock, release on negedge.
  task automatic async_rst();
    edge_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("ar_pll_reset", 32'(pll_reset), 32'd1);
    chk("ar_sys_ready", 32'(sys_ready), 32'd0);
    chk("ar_state",     32'(state_o),   32'd0);
    @(negedge clk);
    sw_rst_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n;
    n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 32'(state_o), 32'(s));
  endtask

  // Lock present from release: fixed edge numbers for the release sequence.
  task automatic run_s1(input string tag);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 3)  chk({tag, "_pll_reset_e3"},  32'(pll_reset), 32'd1);
      if (e == 4)  chk({tag, "_pll_reset_e4"},  32'(pll_reset), 32'd0);
      if (e == 12) chk({tag, "_cpu_rst_n_e12"}, 32'(cpu_rst_n), 32'd0);
      if (e == 13) begin
        chk({tag, "_cpu_rst_n_e13"}, 32'(cpu_rst_n), 32'd1);
        chk({tag, "_sys_ready_e13"}, 32'(sys_ready), 32'd1);
        chk({tag, "_state_e13"},     32'(state_o),   32'd3);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int pll_hi;
    int stab;
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_state",     32'(state_o),   32'd0);
    chk("rst_lock_err",  32'(lock_err),  32'd0);
    rst_n = 1'b1;

    // Scenario 1: release with lock already present
    run_s1("s1");

    // Scenario 4: software CPU reset
    sw_rst_req = 1'b1;
    tick();
    low    = (cpu_rst_n == 1'b0) ? 1 : 0;
    pll_hi = pll_reset ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (cpu_rst_n == 1'b0) low++;
      if (pll_reset) pll_hi++;
    end
    chk("s4_low_cycles", 32'(low), 32'd3);
    chk("s4_pll_reset",  32'(pll_hi), 32'd0);
    chk("s4_back_run",   32'(state_o), 32'd3);

    // Scenario 3: one-cycle lock drop from RUN
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    chk("s3_cpu_a0", 32'(cpu_rst_n), 32'd1);
    tick();
    chk("s3_cpu_a1", 32'(cpu_rst_n), 32'd1);
    tick();
    chk("s3_cpu_a2",   32'(cpu_rst_n), 32'd0);
    chk("s3_state_a2", 32'(state_o),   32'd0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 12) chk("s3_cpu_k12", 32'(cpu_rst_n), 32'd0);
      if (k == 13) chk("s3_cpu_k13", 32'(cpu_rst_n), 32'd1);
    end

    // Scenario 5: lock glitch seen in STABLE at counter 5
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state(3'd2, 30, "s5_reach_stable");
    repeat (3) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("s5_still_stable", 32'(state_o), 32'd2);
    tick();
    chk("s5_wait_lock", 32'(state_o),   32'd1);
    chk("s5_retry",     32'(retry_cnt), 32'd0);
    stab = 0;
    for (int k = 0; k < 20 && state_o != 3'd3; k++) begin
      tick();
      if (state_o == 3'd2) stab++;
    end
    chk("s5_stable_len", 32'(stab),    32'd8);
    chk("s5_run",        32'(state_o), 32'd3);

    // Scenario 6: async reset in RUN, then the release sequence repeats
    async_rst();
    run_s1("s6");

    // Scenario 2: no lock -> timeouts, retries, sticky error
    pll_locked = 1'b0;
    async_rst();
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (e == 4)  chk("s2_pll_reset_e4",  32'(pll_reset), 32'd0);
      if (e == 24) begin
        chk("s2_pll_reset_e24", 32'(pll_reset), 32'd1);
        chk("s2_retry_e24",     32'(retry_cnt), 32'd1);
      end
      if (e == 28) chk("s2_pll_reset_e28", 32'(pll_reset), 32'd0);
      if (e == 48) chk("s2_retry_e48",     32'(retry_cnt), 32'd2);
      if (e == 71) chk("s2_lock_err_e71",  32'(lock_err),  32'd0);
      if (e == 72) begin
        chk("s2_lock_err_e72", 32'(lock_err),  32'd1);
        chk("s2_retry_e72",    32'(retry_cnt), 32'd3);
      end
      if (e == 80) chk("s2_lock_err_e80", 32'(lock_err), 32'd1);
    end
    pll_locked = 1'b1;
    wait_state(3'd3, 40, "s2_reach_run");
    chk("s2_retry_run",    32'(retry_cnt), 32'd0);
    chk("s2_lock_err_run", 32'(lock_err),  32'd1);

    // Randomised phase: lock glitches/outages, software requests, async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        async_rst();
      end else begin
        if (pll_locked) begin
          if ($urandom_range(0, 99) < 2) pll_locked = 1'b0;
        end else begin
          if ($urandom_range(0, 99) < 4) pll_locked = 1'b1;
        end
        sw_rst_req = ($urandom_range(0, 19) == 0);
        tick();
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pll_rst_seq

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Sequences the board PLL (clk_wiz_0) and produces the CPU reset.
- Pulses the PLL reset and waits for lock, with a timeout and retry. Requires lock to stay stable for a qualifying interval, then releases the CPU reset.
- While running, re-sequences on lock loss and supports a software-requested CPU-only reset.
- Runs on the PLL input clock, which is valid before lock; all outputs are registered.

Parameters:
- PLL_RST_CYC, 16: cycles pll_reset is held high per attempt (>=1).
- LOCK_TMO, 4096: cycles to wait for lock before retrying.
- STABLE_CYC, 1024: consecutive locked cycles required before release.
- SW_RST_CYC, 8: cycles cpu_rst_n is held low for a software reset.
- MAX_RETRY, 3: timeouts after which lock_err is set.
- CNT_W, 16: shared counter width; must hold max(all *_CYC, LOCK_TMO)-1.

Ports:
- clk, in, 1: PLL input clock (same net as clk_in1).
- rst_n, in, 1: asynchronous active-low reset.
- pll_locked, in, 1: PLL locked output; asynchronous, synchronised internally.
- sw_rst_req, in, 1: single-cycle software CPU-reset request.
- pll_reset, out, 1: to PLL reset, active high.
- cpu_rst_n, out, 1: CPU/system reset, active low.
- sys_ready, out, 1: high only in RUN.
- lock_err, out, 1: sticky; MAX_RETRY lock timeouts have occurred.
- retry_cnt, out, 2: lock timeouts since the last RUN, saturating at MAX_RETRY.
- state_o, out, 3: current state encoding, for debug.

Behaviour:
- Reset is asynchronous, active-low. While rst_n is low, all of the following hold:
  - state = PLL_RST, counter = 0.
  - pll_reset = 1, cpu_rst_n = 0, sys_ready = 0.
  - lock_err = 0, retry_cnt = 0.
  - Synchroniser flops = 0.
- Edge numbering: edge 1 is the first rising clk after rst_n deasserts.
- Lock synchronisation: pll_locked passes through a 2-flop synchroniser to give locked_s. The FSM uses only locked_s.
- Output timing: outputs are registered and decoded from the next state, so they change on the same edge as the state.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, SW_RST=4. Values 5-7 are illegal and go to PLL_RST.
- The counter clears on every state change and otherwise increments by 1 each cycle.
- PLL_RST:
  - pll_reset=1, cpu_rst_n=0.
  - When counter == PLL_RST_CYC-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0, cpu_rst_n=0.
  - If locked_s, go to STABLE.
  - Else if counter == LOCK_TMO-1, go to PLL_RST and increment retry_cnt (saturating).
  - The increment that makes retry_cnt reach MAX_RETRY sets lock_err. Retries continue indefinitely.
  - If locked_s and the timeout occur in the same cycle, locked_s wins.
- STABLE:
  - cpu_rst_n=0.
  - If !locked_s, go to WAIT_LOCK; retry_cnt is not incremented.
  - Else if counter == STABLE_CYC-1, go to RUN.
- RUN:
  - cpu_rst_n=1, sys_ready=1.
  - On entry, retry_cnt clears; lock_err is not cleared.
  - If !locked_s, go to PLL_RST (cpu_rst_n low on that same edge).
  - Else if sw_rst_req, go to SW_RST.
- SW_RST:
  - cpu_rst_n=0, sys_ready=0, pll_reset=0.
  - If !locked_s, go to PLL_RST (lock loss has priority).
  - Else if counter == SW_RST_CYC-1, go back to RUN.
- sw_rst_req is ignored in every state except RUN.
- Release latency with lock already present: RUN is entered at edge PLL_RST_CYC+1+STABLE_CYC. With defaults this is edge 1041.
- pll_reset falls at edge PLL_RST_CYC.
- rst_n asserted mid-operation forces reset values immediately, with no clock required.

Decomposition:
- Package pll_rst_pkg holds:
  - state encodings (localparams or typedef) for PLL_RST, WAIT_LOCK, STABLE, RUN, SW_RST;
  - the default timing constants.
- One sub-module, sync_2ff (1-bit, async active-low reset to 0), used for pll_locked. It is reusable for other async inputs.

Test Plan:
All scenarios use PLL_RST_CYC=4, LOCK_TMO=20, STABLE_CYC=8, SW_RST_CYC=3, MAX_RETRY=3.
1. pll_locked tied 1, rst_n released -> pll_reset falls at edge 4; cpu_rst_n and sys_ready rise at edge 13; state_o=3.
2. pll_locked tied 0 -> pll_reset pulses 4 cycles every 24 cycles; retry_cnt goes 1,2,3; lock_err=1 at the third timeout (edge 72) and stays set; later lock -> RUN, retry_cnt=0, lock_err still 1.
3. From RUN, drop pll_locked for 1 cycle -> cpu_rst_n low 3 edges later (2 sync + 1); full re-sequence; RUN re-entered 13 edges after the PLL_RST entry.
4. From RUN, 1-cycle sw_rst_req -> cpu_rst_n low for exactly 3 cycles; pll_reset stays 0; back to RUN.
5. During STABLE, drop lock at counter=5 -> WAIT_LOCK, retry_cnt unchanged; restore lock -> full 8-cycle STABLE before RUN.
6. Assert rst_n low between clock edges while in RUN -> cpu_rst_n=0 and pll_reset=1 immediately; after release, sequence repeats as in scenario 1.
